alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle execute sequencer owning the single shared ALU. Accepts one decoded
//  instruction from IDU (valid/ready), drives alu_ctrl/src1/src2/inst for one or two
//  passes, and returns rd data plus next PC to WBU (valid/ready). Branch = compare
//  pass then, if taken, target-add pass on the same ALU; no second adder for targets.
// PARAMETERS
//  XLEN        32   datapath width (all data/pc ports)
//  RST_PC_INC  4    local PC increment for fall-through / link value
// PORTS
//  clk         in   1     clock
//  rst         in   1     reset, asynchronous, active-high
//  in_valid    in   1     IDU has an instruction
//  in_ready    out  1     sequencer can accept (IDLE only)
//  in_inst     in   32    raw instruction (forwarded to ALU for shamt)
//  in_pc       in   32    instruction PC
//  in_rs1      in   32    x[rs1]
//  in_rs2      in   32    x[rs2]
//  in_imm      in   32    sign-extended immediate
//  in_op       in   5     ALU op code for pass 1 (ALU op set of pkg)
//  in_kind     in   2     0 ALU, 1 BRANCH, 2 JAL, 3 JALR
//  in_use_imm  in   1     kind ALU: src2 = imm (1) / rs2 (0)
//  alu_inst    out  32    to ALU instruction
//  alu_src1    out  32    to ALU src1
//  alu_src2    out  32    to ALU src2
//  alu_ctrl    out  5     to ALU op select
//  alu_result  in   32    from ALU (combinational)
//  out_valid   out  1     result available
//  out_ready   in   1     WBU accepts
//  out_rd_data out  32    value for rd
//  out_next_pc out  32    next PC
//  out_taken   out  1     control transfer taken (branch taken, JAL, JALR)
// BEHAVIOUR
//  States IDLE -> PASS1 -> [PASS2] -> DONE -> IDLE. in_ready = (state==IDLE).
//  IDLE: in_valid -> capture all in_* into regs, go PASS1. ALU outputs driven 0.
//  PASS1 per kind (ALU combinational; result captured at end of cycle):
//   ALU:   ctrl=op, src1=rs1, src2=use_imm?imm:rs2; rd=result, npc=pc+4, taken=0 -> DONE
//   BRANCH:ctrl=op, src1=rs1, src2=rs2; only result[0] used; 0 -> rd=0, npc=pc+4,
//          taken=0, DONE; 1 -> PASS2
//   JAL:   ctrl=00000, src1=pc, src2=imm; npc=result, rd=pc+4, taken=1 -> DONE
//   JALR:  ctrl=00011, src1=rs1, src2=imm; npc=result (bit0 cleared), rd=pc+4, taken=1
//  PASS2 (taken branch only): ctrl=00000, src1=pc, src2=imm; npc=result, rd=0, taken=1.
//  alu_inst = captured inst in PASS1/PASS2, 0 otherwise.
//  DONE: out_valid=1; out_* stable until out_valid&&out_ready, then IDLE (no bypass;
//   next accept earliest the cycle after handshake).
//  Latency accept-edge N: out_valid from N+2 (single pass), N+3 (taken branch).
//  pc+4 wraps mod 2^32 (0xFFFF_FFFC -> 0x0000_0000); all arithmetic 32-bit unsigned.
//  in_valid while not IDLE: ignored, not captured. out_ready high outside DONE: no effect.
//  Reset (any state, any cycle): state IDLE, in-flight instruction dropped;
//   out_valid=0, out_rd_data=0, out_next_pc=0, out_taken=0, alu_*=0, in_ready=1
//   once released.
// STRUCTURE
//  alu_seq_pkg: ALU op constants (ADD 00000, ADD_CLR0 00011, BEQ 01101, BNE 10010,
//   BLT 10000, BGE 01110, BLTU 10001, BGEU 01111), KIND_* encodings, state enum.
//  No sub-module; ALU is instantiated by the parent and wired to alu_* ports.
// TESTING
//  ADD: rs1=5, rs2=7, op=00000, kind=0 -> rd=12, npc=pc+4, taken=0, out_valid at N+2.
//  BEQ taken: pc=0x8000_0000, rs1=rs2=3, imm=0x10 -> npc=0x8000_0010, taken=1, at N+3.
//  BNE not taken: rs1=rs2=9, imm=0x40, pc=0x100 -> npc=0x104, taken=0, at N+2.
//  JALR: rs1=0x1003, imm=4, pc=0x200 -> npc=0x1006, rd=0x204; pc=0xFFFF_FFFC JAL -> rd=0.
//  Backpressure: out_ready low 5 cycles -> outputs stable, in_ready low, in_valid ignored.
//  Reset asserted in PASS2 -> out_valid=0, outputs 0, IDLE; next instr completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the execute sequencer: ALU op codes, instruction
// kinds and sequencer states.
package alu_seq_pkg;

    localparam logic [4:0] OP_ADD      = 5'b00000;
    localparam logic [4:0] OP_ADD_CLR0 = 5'b00011;
    localparam logic [4:0] OP_BEQ      = 5'b01101;
    localparam logic [4:0] OP_BNE      = 5'b10010;
    localparam logic [4:0] OP_BLT      = 5'b10000;
    localparam logic [4:0] OP_BGE      = 5'b01110;
    localparam logic [4:0] OP_BLTU     = 5'b10001;
    localparam logic [4:0] OP_BGEU     = 5'b01111;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_JAL    = 2'd2,
        KIND_JALR   = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle execute sequencer: drives the shared ALU for one or two passes
// per instruction and hands rd data / next PC to writeback.
module alu_seq_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RST_PC_INC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_op,
    input  logic [1:0]      in_kind,
    input  logic            in_use_imm,
    output logic [31:0]     alu_inst,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd_data,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_taken
);
    import alu_seq_pkg::*;

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;

    logic [31:0]     alu_inst_q, alu_inst_d;
    logic [XLEN-1:0] alu_src1_q, alu_src1_d;
    logic [XLEN-1:0] alu_src2_q, alu_src2_d;
    logic [4:0]      alu_ctrl_q, alu_ctrl_d;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic            taken_q, taken_d;

    logic [XLEN-1:0] pc_inc;

    assign pc_inc = pc_q + XLEN'(RST_PC_INC);

    // ALU operands are registered one state ahead so they are stable for the
    // whole pass in which the combinational result is captured.
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        alu_inst_d  = '0;
        alu_src1_d  = '0;
        alu_src2_d  = '0;
        alu_ctrl_d  = '0;
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        npc_d       = npc_q;
        taken_d     = taken_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    kind_d     = kind_e'(in_kind);
                    inst_d     = in_inst;
                    pc_d       = in_pc;
                    imm_d      = in_imm;
                    state_d    = ST_PASS1;
                    alu_inst_d = in_inst;
                    case (kind_e'(in_kind))
                        KIND_ALU: begin
                            alu_ctrl_d = in_op;
                            alu_src1_d = in_rs1;
                            alu_src2_d = in_use_imm ? in_imm : in_rs2;
                        end
                        KIND_BRANCH: begin
                            alu_ctrl_d = in_op;
                            alu_src1_d = in_rs1;
                            alu_src2_d = in_rs2;
                        end
                        KIND_JAL: begin
                            alu_ctrl_d = OP_ADD;
                            alu_src1_d = in_pc;
                            alu_src2_d = in_imm;
                        end
                        default: begin
                            alu_ctrl_d = OP_ADD_CLR0;
                            alu_src1_d = in_rs1;
                            alu_src2_d = in_imm;
                        end
                    endcase
                end
            end

            ST_PASS1: begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                case (kind_q)
                    KIND_ALU: begin
                        rd_d    = alu_result;
                        npc_d   = pc_inc;
                        taken_d = 1'b0;
                    end
                    KIND_BRANCH: begin
                        if (alu_result[0]) begin
                            // Taken: reuse the ALU for the target add.
                            state_d     = ST_PASS2;
                            out_valid_d = 1'b0;
                            alu_inst_d  = inst_q;
                            alu_ctrl_d  = OP_ADD;
                            alu_src1_d  = pc_q;
                            alu_src2_d  = imm_q;
                        end else begin
                            rd_d    = '0;
                            npc_d   = pc_inc;
                            taken_d = 1'b0;
                        end
                    end
                    KIND_JAL: begin
                        rd_d    = pc_inc;
                        npc_d   = alu_result;
                        taken_d = 1'b1;
                    end
                    default: begin
                        rd_d    = pc_inc;
                        npc_d   = {alu_result[XLEN-1:1], 1'b0};
                        taken_d = 1'b1;
                    end
                endcase
            end

            ST_PASS2: begin
                state_d     = ST_DONE;
                out_valid_d = 1'b1;
                rd_d        = '0;
                npc_d       = alu_result;
                taken_d     = 1'b1;
            end

            default: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            kind_q      <= KIND_ALU;
            inst_q      <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            alu_inst_q  <= '0;
            alu_src1_q  <= '0;
            alu_src2_q  <= '0;
            alu_ctrl_q  <= '0;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            npc_q       <= '0;
            taken_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            alu_inst_q  <= alu_inst_d;
            alu_src1_q  <= alu_src1_d;
            alu_src2_q  <= alu_src2_d;
            alu_ctrl_q  <= alu_ctrl_d;
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            npc_q       <= npc_d;
            taken_q     <= taken_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign alu_inst    = alu_inst_q;
    assign alu_src1    = alu_src1_q;
    assign alu_src2    = alu_src2_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign out_valid   = out_valid_q;
    assign out_rd_data = rd_q;
    assign out_next_pc = npc_q;
    assign out_taken   = taken_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed instructions, a behavioural ALU on the
// alu_* ports, and a scoreboard checked by an independent output monitor.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_use_imm;
    logic [31:0] in_inst, in_pc, in_rs1, in_rs2, in_imm;
    logic [4:0]  in_op;
    logic [1:0]  in_kind;
    logic [31:0] alu_inst, alu_src1, alu_src2, alu_result;
    logic [4:0]  alu_ctrl;
    logic        out_valid, out_ready, out_taken;
    logic [31:0] out_rd_data, out_next_pc;

    alu_seq_ctrl #(.XLEN(32), .RST_PC_INC(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_op(in_op), .in_kind(in_kind), .in_use_imm(in_use_imm),
        .alu_inst(alu_inst), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd_data(out_rd_data), .out_next_pc(out_next_pc), .out_taken(out_taken)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            OP_ADD:      return a + b;
            OP_ADD_CLR0: return (a + b) & 32'hFFFF_FFFE;
            OP_BEQ:      return {31'b0, a == b};
            OP_BNE:      return {31'b0, a != b};
            OP_BLT:      return {31'b0, $signed(a) < $signed(b)};
            OP_BGE:      return {31'b0, $signed(a) >= $signed(b)};
            OP_BLTU:     return {31'b0, a < b};
            OP_BGEU:     return {31'b0, a >= b};
            default:     return 32'h0;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_ctrl, alu_src1, alu_src2);

    typedef struct {
        logic [31:0] rd;
        logic [31:0] npc;
        logic        taken;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: while a result is presented, it must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {31'b0, out_valid}, 32'h0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 32'(cyc + 1 - sb[0].acc), 32'(sb[0].lat));
                end
                chk("rd_data", out_rd_data, sb[0].rd);
                chk("next_pc", out_next_pc, sb[0].npc);
                chk("taken", {31'b0, out_taken}, {31'b0, sb[0].taken});
                chk("in_ready_busy", {31'b0, in_ready}, 32'h0);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [1:0] kind, input logic [4:0] op, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic use_imm, input logic [31:0] rd, input logic [31:0] npc,
                        input logic taken, input int lat, input logic [4:0] e_ctrl,
                        input logic [31:0] e_s1, input logic [31:0] e_s2);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", {31'b0, in_ready}, 32'h1);
        in_valid   = 1'b1;
        in_kind    = kind;
        in_op      = op;
        in_pc      = pc;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_use_imm = use_imm;
        in_inst    = 32'hC0DE_0000 ^ pc;
        e.rd = rd; e.npc = npc; e.taken = taken; e.lat = lat; e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        chk("p1_ctrl", {27'b0, alu_ctrl}, {27'b0, e_ctrl});
        chk("p1_src1", alu_src1, e_s1);
        chk("p1_src2", alu_src2, e_s2);
        chk("p1_inst", alu_inst, 32'hC0DE_0000 ^ pc);
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_kind = '0; in_op = '0; in_pc = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_use_imm = 1'b0; in_inst = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_rd", out_rd_data, 32'h0);
        chk("rst_npc", out_next_pc, 32'h0);
        chk("rst_ctrl", {27'b0, alu_ctrl}, 32'h0);
        chk("rst_src1", alu_src1, 32'h0);
        rst = 1'b0;
        #1 chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

        //    kind         op          pc            rs1           rs2           imm           ui  rd            npc           tk lat ctrl         s1            s2
        send(KIND_ALU,    OP_ADD,     32'h0000_1000, 32'd5,        32'd7,        32'h0,        0, 32'd12,       32'h0000_1004, 0, 2, OP_ADD,     32'd5,        32'd7);
        wait_done();
        send(KIND_ALU,    OP_ADD,     32'hFFFF_FFFC, 32'h10,       32'h99,       32'hFFFF_FFF0, 1, 32'h0,       32'h0,         0, 2, OP_ADD,     32'h10,       32'hFFFF_FFF0);
        wait_done();
        send(KIND_BRANCH, OP_BEQ,     32'h8000_0000, 32'd3,        32'd3,        32'h10,       0, 32'h0,        32'h8000_0010, 1, 3, OP_BEQ,     32'd3,        32'd3);
        wait_done();
        send(KIND_BRANCH, OP_BNE,     32'h0000_0100, 32'd9,        32'd9,        32'h40,       0, 32'h0,        32'h0000_0104, 0, 2, OP_BNE,     32'd9,        32'd9);
        wait_done();
        send(KIND_JALR,   5'b11111,   32'h0000_0200, 32'h1003,     32'h55,       32'h4,        0, 32'h204,      32'h0000_1006, 1, 2, OP_ADD_CLR0, 32'h1003,    32'h4);
        wait_done();
        send(KIND_JAL,    5'b10101,   32'hFFFF_FFFC, 32'h77,       32'h66,       32'h20,       0, 32'h0,        32'h0000_001C, 1, 2, OP_ADD,     32'hFFFF_FFFC, 32'h20);
        wait_done();
        send(KIND_BRANCH, OP_BLT,     32'h0000_0400, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFF8, 0, 32'h0,       32'h0000_03F8, 1, 3, OP_BLT,     32'hFFFF_FFFF, 32'd1);
        wait_done();
        send(KIND_BRANCH, OP_BGEU,    32'h0000_0500, 32'd1,        32'hFFFF_FFFF, 32'h100,     0, 32'h0,        32'h0000_0504, 0, 2, OP_BGEU,    32'd1,        32'hFFFF_FFFF);
        wait_done();
        send(KIND_BRANCH, OP_BGE,     32'h0000_0600, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h100,   0, 32'h0,        32'h0000_0700, 1, 3, OP_BGE,     32'hFFFF_FFFB, 32'hFFFF_FFFB);
        wait_done();

        // Backpressure: hold result for 5 cycles while junk is offered on the input.
        out_ready = 1'b0;
        send(KIND_ALU,    OP_ADD,     32'h0000_0700, 32'h1111_1111, 32'h2222_2222, 32'h0,     0, 32'h3333_3333, 32'h0000_0704, 0, 2, OP_ADD,   32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        chk("bp_valid", {31'b0, out_valid}, 32'h1);
        in_valid = 1'b1; in_kind = KIND_JAL; in_pc = 32'hDEAD_BEE0; in_imm = 32'h8;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done();
        send(KIND_ALU,    OP_ADD,     32'h0000_0800, 32'd40,       32'd2,        32'd100,      1, 32'd140,      32'h0000_0804, 0, 2, OP_ADD,     32'd40,       32'd100);
        wait_done();

        // Reset while the taken-branch target pass is in progress.
        send(KIND_BRANCH, OP_BEQ,     32'h0000_0900, 32'd1,        32'd1,        32'h80,       0, 32'h0,        32'h0000_0980, 1, 3, OP_BEQ,     32'd1,        32'd1);
        @(negedge clk);
        chk("p2_ctrl", {27'b0, alu_ctrl}, 32'h0);
        chk("p2_src1", alu_src1, 32'h0000_0900);
        chk("p2_src2", alu_src2, 32'h80);
        #1 rst = 1'b1;
        sb.delete();
        seen = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("mid_rst_rd", out_rd_data, 32'h0);
        chk("mid_rst_npc", out_next_pc, 32'h0);
        chk("mid_rst_taken", {31'b0, out_taken}, 32'h0);
        chk("mid_rst_src1", alu_src1, 32'h0);
        chk("mid_rst_inst", alu_inst, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_ready", {31'b0, in_ready}, 32'h1);
        send(KIND_JALR,   OP_ADD,     32'h0000_0A00, 32'h2000,     32'h0,        32'h10,       0, 32'h0000_0A04, 32'h0000_2010, 1, 2, OP_ADD_CLR0, 32'h2000,  32'h10);
        wait_done();

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
